// File: rtl/period_generator_if.sv
// period_generator_if
// Bundles the control, configuration and status signals of the period
// generator into one interface. The clock and reset are not part of it.
//
//   start        request to begin generation (sampled only in IDLE)
//   stop         abort request (sampled only in RUN)
//   period_us    period length in microseconds
//   high_us      high time per period in microseconds
//   num_periods  periods to generate, 0 = continuous until stop
//   ready        generator idle and able to accept a start
//   busy         generator producing a waveform
//   done_tick    one-cycle pulse when a run finishes
//   err_tick     one-cycle pulse when a start was rejected
//   signal_out   generated waveform
//   periods_done completed full periods of the current/last run
//
// master: the block that drives start/stop/config (controller or bench)
// slave : the period generator itself
interface period_generator_if #(
    parameter int PW = 20
);
    logic          start;
    logic          stop;
    logic [PW-1:0] period_us;
    logic [PW-1:0] high_us;
    logic [7:0]    num_periods;
    logic          ready;
    logic          busy;
    logic          done_tick;
    logic          err_tick;
    logic          signal_out;
    logic [7:0]    periods_done;

    modport master (
        output start, stop, period_us, high_us, num_periods,
        input  ready, busy, done_tick, err_tick, signal_out, periods_done
    );

    modport slave (
        input  start, stop, period_us, high_us, num_periods,
        output ready, busy, done_tick, err_tick, signal_out, periods_done
    );
endinterface

// File: rtl/period_generator.sv
// period_generator
// Produces a periodic pulse waveform whose period and high time are given
// in microseconds. A free-running prescaler (tick_cnt, N clocks per us)
// advances a microsecond counter (us_cnt) inside each period. The run lasts
// num_periods full periods, or until stop when num_periods is 0.
//
// Ports:
//   clk    system clock, rising-edge
//   rst_n  asynchronous active-low reset
//   bus    period_generator_if.slave (start/stop/config in, status and
//          waveform out)
//
// Parameters:
//   N   system clocks per microsecond
//   TW  width of the prescaler, 2**TW must be >= N
//   PW  width of the period/high-time fields (must match the interface)
module period_generator #(
    parameter int N  = 50,
    parameter int TW = 6,
    parameter int PW = 20
) (
    input logic               clk,
    input logic               rst_n,
    period_generator_if.slave bus
);

    localparam logic [TW-1:0] TICK_LAST = TW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state;
    state_t        state_next;

    // Latched configuration, only rewritten on an accepted start.
    logic [PW-1:0] period_r;
    logic [PW-1:0] high_r;
    logic [7:0]    num_r;

    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] us_cnt;
    logic [7:0]    periods_done;
    logic          signal_out;
    logic          err_tick;

    // Decoded conditions shared by the FSM and the datapath.
    logic          cfg_valid;
    logic          tick_wrap;
    logic          period_end;
    logic          last_period;
    logic [PW-1:0] us_next;

    // A start is only acceptable when the waveform has at least one high
    // and one low microsecond per period.
    always_comb begin
        cfg_valid = (bus.period_us >= PW'(2)) &&
                    (bus.high_us   >= PW'(1)) &&
                    (bus.high_us   <  bus.period_us);
    end

    // Position decoding inside the current period. us_next is the us count
    // that will hold after this edge when no period boundary is crossed; the
    // waveform level is derived from it so the output is registered yet
    // lines up exactly with the microsecond boundaries. last_period compares
    // in 9 bits so a saturated periods_done cannot wrap into a false match.
    always_comb begin
        tick_wrap   = (tick_cnt == TICK_LAST);
        period_end  = tick_wrap && (us_cnt == (period_r - PW'(1)));
        last_period = (num_r != 8'd0) &&
                      (({1'b0, periods_done} + 9'd1) == {1'b0, num_r});
        us_next     = tick_wrap ? (us_cnt + PW'(1)) : us_cnt;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A stop that lands on a period end still finishes the
    // run; both paths lead to DONE, and the datapath counts the period.
    // DONE always falls back to IDLE so a start must be held into IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start && cfg_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((period_end && last_period) || bus.stop) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: config latch, prescaler, us counter, period counter, the
    // registered waveform and the rejected-start pulse. err_tick defaults
    // low each cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_r     <= '0;
            high_r       <= '0;
            num_r        <= '0;
            tick_cnt     <= '0;
            us_cnt       <= '0;
            periods_done <= '0;
            signal_out   <= 1'b0;
            err_tick     <= 1'b0;
        end else begin
            err_tick <= 1'b0;
            case (state)
                IDLE: begin
                    signal_out <= 1'b0;
                    if (bus.start) begin
                        if (cfg_valid) begin
                            period_r     <= bus.period_us;
                            high_r       <= bus.high_us;
                            num_r        <= bus.num_periods;
                            tick_cnt     <= '0;
                            us_cnt       <= '0;
                            periods_done <= '0;
                            signal_out   <= 1'b1;
                        end else begin
                            err_tick <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (period_end) begin
                        if (periods_done != 8'hFF) begin
                            periods_done <= periods_done + 8'd1;
                        end
                        if (last_period || bus.stop) begin
                            signal_out <= 1'b0;
                        end else begin
                            tick_cnt   <= '0;
                            us_cnt     <= '0;
                            signal_out <= 1'b1;
                        end
                    end else if (bus.stop) begin
                        signal_out <= 1'b0;
                    end else begin
                        tick_cnt   <= tick_wrap ? '0 : (tick_cnt + TW'(1));
                        us_cnt     <= us_next;
                        signal_out <= (us_next < high_r);
                    end
                end
                default: begin
                    signal_out <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        bus.ready        = (state == IDLE);
        bus.busy         = (state == RUN);
        bus.done_tick    = (state == DONE);
        bus.err_tick     = err_tick;
        bus.signal_out   = signal_out;
        bus.periods_done = periods_done;
    end

endmodule

// File: tb/tb_period_generator.sv
// tb_period_generator
// Drives period_generator (N=4) through a table of directed runs followed
// by randomized runs. Expected waveform, period counts and handshake
// behaviour come from a cycle-index model: cycle c after an accepted start
// is high when (c mod period*N) < high*N, and c/(period*N) periods are
// complete at cycle c.
module tb_period_generator;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int PW = 20;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    period_generator_if #(.PW(PW)) bus ();

    period_generator #(
        .N (N),
        .TW(TW),
        .PW(PW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // 10 ns clock; inputs change and outputs are sampled 1 ns after posedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        int num;
        int stopAt;
        bit scramble;
        int expPd;
    } vec_t;

    // Compare and record one value.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int expSig(input int c, input int p, input int h);
        return ((c % (p * N)) < (h * N)) ? 1 : 0;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Apply one start with the given config and follow the run to IDLE.
    // stopAt is the cycle index (after the accepted start) on whose closing
    // edge stop is applied; -1 means no stop. finalPd returns -1 for a
    // rejected start, else periods_done seen in DONE.
    task automatic applyStimulus(input int p, input int h, input int num,
                                 input int stopAt, input bit scramble,
                                 output int finalPd);
        bit valid;
        int pn;
        int last;
        valid = (p >= 2) && (h >= 1) && (h < p);
        bus.period_us   = PW'(p);
        bus.high_us     = PW'(h);
        bus.num_periods = 8'(num);
        bus.start       = 1'b1;
        bus.stop        = 1'b0;
        step();
        bus.start = 1'b0;
        if (!valid) begin
            checkOutput("rej_err_tick", bus.err_tick, 1);
            checkOutput("rej_ready", bus.ready, 1);
            checkOutput("rej_signal", bus.signal_out, 0);
            finalPd = bus.err_tick ? -1 : int'(bus.periods_done);
            step();
            checkOutput("rej_err_clear", bus.err_tick, 0);
            checkOutput("rej_still_idle", bus.ready, 1);
            return;
        end
        pn   = p * N;
        last = (num == 0) ? stopAt : (num * pn - 1);
        if (stopAt >= 0 && stopAt < last) last = stopAt;
        for (int c = 0; c <= last; c++) begin
            checkOutput($sformatf("signal_out[c=%0d]", c), bus.signal_out, expSig(c, p, h));
            checkOutput("busy", bus.busy, 1);
            checkOutput("run_periods_done", bus.periods_done, sat255(c / pn));
            if (c == last) begin
                bus.start = 1'b0;
                bus.stop  = (c == stopAt);
            end else if (scramble) begin
                bus.period_us = PW'($urandom);
                bus.high_us   = PW'($urandom);
                bus.start     = 1'($urandom);
            end
            step();
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        checkOutput("done_tick", bus.done_tick, 1);
        checkOutput("done_signal", bus.signal_out, 0);
        checkOutput("done_ready", bus.ready, 0);
        checkOutput("done_periods", bus.periods_done, sat255((last + 1) / pn));
        finalPd = int'(bus.periods_done);
        step();
        checkOutput("post_done_tick", bus.done_tick, 0);
        checkOutput("post_ready", bus.ready, 1);
        checkOutput("post_periods_hold", bus.periods_done, sat255((last + 1) / pn));
    endtask

    vec_t vecs[9];

    initial begin
        int pd;
        int p, h, num, stopAt;
        checks = 0;
        errors = 0;

        vecs[0] = '{p:5, h:2, num:3, stopAt:-1,   scramble:1'b0, expPd:3};
        vecs[1] = '{p:5, h:5, num:3, stopAt:-1,   scramble:1'b0, expPd:-1};
        vecs[2] = '{p:5, h:0, num:3, stopAt:-1,   scramble:1'b0, expPd:-1};
        vecs[3] = '{p:1, h:1, num:3, stopAt:-1,   scramble:1'b0, expPd:-1};
        vecs[4] = '{p:3, h:1, num:0, stopAt:37,   scramble:1'b0, expPd:3};
        vecs[5] = '{p:5, h:2, num:5, stopAt:39,   scramble:1'b0, expPd:2};
        vecs[6] = '{p:4, h:3, num:2, stopAt:-1,   scramble:1'b1, expPd:2};
        vecs[7] = '{p:3, h:2, num:2, stopAt:23,   scramble:1'b0, expPd:2};
        vecs[8] = '{p:2, h:1, num:0, stopAt:2100, scramble:1'b0, expPd:255};

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.period_us   = '0;
        bus.high_us     = '0;
        bus.num_periods = '0;
        step();
        step();
        checkOutput("reset_ready", bus.ready, 1);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_signal", bus.signal_out, 0);
        checkOutput("reset_periods", bus.periods_done, 0);
        checkOutput("reset_done_tick", bus.done_tick, 0);
        checkOutput("reset_err_tick", bus.err_tick, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].p, vecs[i].h, vecs[i].num, vecs[i].stopAt,
                          vecs[i].scramble, pd);
            checkOutput($sformatf("table_result[%0d]", i), pd, vecs[i].expPd);
        end

        // A start arriving during DONE is ignored; held into IDLE it is taken.
        bus.period_us   = PW'(2);
        bus.high_us     = PW'(1);
        bus.num_periods = 8'd1;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) step();
        bus.start = 1'b1;
        step();
        checkOutput("held_done_tick", bus.done_tick, 1);
        checkOutput("held_periods", bus.periods_done, 1);
        step();
        checkOutput("held_ignored_in_done", bus.busy, 0);
        checkOutput("held_idle_ready", bus.ready, 1);
        step();
        bus.start = 1'b0;
        checkOutput("held_accepted_busy", bus.busy, 1);
        checkOutput("held_accepted_signal", bus.signal_out, 1);
        checkOutput("held_accepted_periods", bus.periods_done, 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        checkOutput("held_stop_done", bus.done_tick, 1);
        checkOutput("held_stop_periods", bus.periods_done, 0);
        step();

        // Asynchronous reset in the middle of a high phase.
        bus.period_us   = PW'(5);
        bus.high_us     = PW'(2);
        bus.num_periods = 8'd0;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        checkOutput("pre_reset_signal", bus.signal_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_signal", bus.signal_out, 0);
        checkOutput("async_reset_ready", bus.ready, 1);
        checkOutput("async_reset_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("after_reset_ready", bus.ready, 1);
        checkOutput("after_reset_periods", bus.periods_done, 0);
        checkOutput("after_reset_done", bus.done_tick, 0);

        // Randomized runs, including invalid configurations and random stops.
        for (int t = 0; t < 40; t++) begin
            p   = int'($urandom_range(1, 8));
            h   = int'($urandom_range(0, 8));
            num = int'($urandom_range(0, 3));
            if (num == 0) begin
                stopAt = int'($urandom_range(0, 4 * p * N - 1));
            end else if ($urandom_range(0, 1) == 1) begin
                stopAt = int'($urandom_range(0, num * p * N + 1));
            end else begin
                stopAt = -1;
            end
            applyStimulus(p, h, num, stopAt, 1'($urandom), pd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/period_generator.md
Name: period_generator

Overview:
Generates a periodic square/pulse waveform whose period and high time are programmed in microseconds. It is the transmit-side counterpart of the period measurement block and uses the same 1 us timebase (N clocks per us) and the same start/ready/done_tick handshake. It can drive a measurement block directly for self-test, or drive external timing pins. Output runs for a programmed number of periods, or continuously until stopped.

Parameters:
N, 50, system clocks per microsecond (50 MHz clock -> 1 us tick)
TW, 6, width of the us-tick counter; must satisfy 2^TW >= N
PW, 20, width of the period/high-time fields in us

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to begin generation; sampled only in IDLE
stop  in  1  abort request; sampled only in RUN
period_us  in  PW  period length in us; latched on accepted start
high_us  in  PW  high time per period in us; latched on accepted start
num_periods  in  8  periods to generate; 0 = continuous until stop
ready  out  1  high in IDLE (combinational from state)
busy  out  1  high in RUN (combinational from state)
done_tick  out  1  one-cycle pulse in DONE
err_tick  out  1  one-cycle registered pulse on a rejected start
signal_out  out  1  generated waveform, registered
periods_done  out  8  completed full periods; holds after DONE until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; signal_out=0; periods_done=0; err_tick=0; all internal counters and latched config=0. ready=1, busy=0, done_tick=0 after reset.
- States: IDLE, RUN, DONE. Undefined encodings go to IDLE.
- Config validity: period_us>=2, high_us>=1, high_us<period_us.
- IDLE: start=1 and valid config -> latch period_us/high_us/num_periods, clear tick_cnt, us_cnt, periods_done, go to RUN, signal_out=1 on that same edge.
- IDLE: start=1 and invalid config -> err_tick=1 for one cycle, stay in IDLE, latched config unchanged.
- RUN:
  - tick_cnt counts 0..N-1; at N-1 it wraps to 0 and us_cnt increments.
  - signal_out is registered to 1 when next us_cnt < high_us, else 0. Every high phase is exactly high_us*N clocks. Consecutive rising edges are exactly period_us*N clocks apart.
  - Period end (us_cnt==period_us-1 and tick_cnt==N-1): periods_done += 1, saturating at 255.
  - At period end, if num_periods!=0 and periods_done+1==num_periods -> DONE, signal_out=0.
  - Otherwise at period end, us_cnt=0 and signal_out=1 (new period begins).
- RUN with stop=1: go to DONE on the next edge and drive signal_out=0. The partial period is not counted. If stop coincides with a period end, that period is counted and stop still goes to DONE.
- RUN ignores start. IDLE and DONE ignore stop.
- DONE: done_tick=1 for exactly one cycle, signal_out=0, then return to IDLE. A start that arrives while in DONE is ignored; it must be held into IDLE to be accepted.
- Continuous mode (num_periods=0): runs until stop. periods_done saturates at 255 and generation continues.
- Reset mid-RUN: immediate return to reset values; signal_out drops to 0 asynchronously.
- Latched config is immune to input changes during RUN.

Test Plan:
- Use N=4. Reset -> ready=1, signal_out=0, periods_done=0. Then start with period_us=5, high_us=2, num_periods=3 -> signal_out high 8 clks and low 12 clks, three times. Rising edges 20 clks apart, done_tick once, periods_done=3, ready=1.
- Invalid starts: high_us=5 with period_us=5; high_us=0; period_us=1 -> err_tick one cycle each, state stays IDLE, signal_out=0.
- Continuous mode (num_periods=0, period_us=3, high_us=1), stop asserted mid-high of the 4th period -> signal_out=0 next edge, done_tick one cycle, periods_done=3.
- Stop on the exact period-end clock of period 2 -> periods_done=2, DONE next edge.
- Change period_us/high_us and pulse start during RUN -> waveform unchanged, start ignored.
- Assert rst_n=0 mid-RUN -> signal_out=0 immediately. After release: ready=1, periods_done=0.
- Loopback into the period measurement block, both at N=50, period_us=1000 -> measured period=1000.
